// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - mode encodings shared by the LED pattern engine
package led_pattern_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_STATIC  = 2'd0,
    MODE_ROT_R   = 2'd1,
    MODE_ROT_L   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running prescaler emitting a one-cycle tick every DIV clocks
module tick_divider #(
  parameter int DIV = 1200000
) (
  input  logic clk_12mhz,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - rotate/static/breathe LED engine with tick-aligned config updates
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int                  NUM_LEDS     = 8,
  parameter int                  TICK_DIV     = 1200000,
  parameter int                  PWM_BITS     = 4,
  parameter logic [NUM_LEDS-1:0] INIT_PATTERN = NUM_LEDS'(8'b00111011)
) (
  input  logic                clk_12mhz,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [NUM_LEDS-1:0] cfg_pattern,
  output logic                tick,
  output logic [NUM_LEDS-1:0] leds
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  mode_e               mode, mode_n;
  logic [NUM_LEDS-1:0] pattern, pattern_n;
  logic [PWM_BITS-1:0] duty, duty_n;
  logic                dir_up, dir_up_n;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pend_valid, pend_valid_n;
  mode_e               pend_mode, pend_mode_n;
  logic [NUM_LEDS-1:0] pend_pattern, pend_pattern_n;
  logic [NUM_LEDS-1:0] leds_n;

  tick_divider #(.DIV(TICK_DIV)) u_tick_divider (
    .clk_12mhz (clk_12mhz),
    .reset     (reset),
    .tick      (tick)
  );

  // The pending slot is the only buffer, so readiness is simply "slot empty".
  assign cfg_ready = ~pend_valid;

  always_comb begin
    mode_n         = mode;
    pattern_n      = pattern;
    duty_n         = duty;
    dir_up_n       = dir_up;
    pend_valid_n   = pend_valid;
    pend_mode_n    = pend_mode;
    pend_pattern_n = pend_pattern;

    if (tick) begin
      if (pend_valid) begin
        mode_n       = pend_mode;
        pattern_n    = pend_pattern;
        duty_n       = '0;
        dir_up_n     = 1'b1;
        pend_valid_n = 1'b0;
      end else begin
        case (mode)
          MODE_ROT_R: pattern_n = {pattern[0], pattern[NUM_LEDS-1:1]};
          MODE_ROT_L: pattern_n = {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
          MODE_BREATHE: begin
            if (dir_up) begin
              if (duty == DUTY_MAX) begin
                dir_up_n = 1'b0;
                duty_n   = DUTY_MAX - 1'b1;
              end else begin
                duty_n = duty + 1'b1;
              end
            end else begin
              if (duty == '0) begin
                dir_up_n = 1'b1;
                duty_n   = PWM_BITS'(1);
              end else begin
                duty_n = duty - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Accept only with an empty slot, so this never collides with the apply above.
    if (cfg_valid && cfg_ready) begin
      pend_valid_n   = 1'b1;
      pend_mode_n    = mode_e'(cfg_mode);
      pend_pattern_n = cfg_pattern;
    end

    if (mode == MODE_BREATHE) begin
      leds_n = pattern & {NUM_LEDS{pwm_cnt < duty}};
    end else begin
      leds_n = pattern;
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      mode         <= MODE_ROT_R;
      pattern      <= INIT_PATTERN;
      duty         <= '0;
      dir_up       <= 1'b1;
      pwm_cnt      <= '0;
      pend_valid   <= 1'b0;
      pend_mode    <= MODE_STATIC;
      pend_pattern <= '0;
      leds         <= INIT_PATTERN;
    end else begin
      mode         <= mode_n;
      pattern      <= pattern_n;
      duty         <= duty_n;
      dir_up       <= dir_up_n;
      pwm_cnt      <= pwm_cnt + 1'b1;
      pend_valid   <= pend_valid_n;
      pend_mode    <= pend_mode_n;
      pend_pattern <= pend_pattern_n;
      leds         <= leds_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed checks of ticks, modes, config handshake and reset
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  logic       clk_12mhz = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] cfg_pattern = 8'h00;
  logic       cfg_ready;
  logic       tick;
  logic [7:0] leds;

  int n_vectors = 0;
  int n_miscompares = 0;
  int cyc = 0;

  always #5 clk_12mhz = ~clk_12mhz;

  led_pattern_gen #(
    .NUM_LEDS     (8),
    .TICK_DIV     (4),
    .PWM_BITS     (2),
    .INIT_PATTERN (8'b00111011)
  ) dut (
    .clk_12mhz   (clk_12mhz),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_pattern (cfg_pattern),
    .tick        (tick),
    .leds        (leds)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk_12mhz);
    cyc++;
  endtask

  // Returns at a falling edge with reset just released: the current cycle is cycle 0.
  task automatic start();
    reset = 1'b1;
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk_12mhz);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic offer(input logic [1:0] m, input logic [7:0] p);
    cfg_valid = 1'b1;
    cfg_mode = m;
    cfg_pattern = p;
  endtask

  initial begin
    int duty_seq [8];
    logic [7:0] exp_leds;
    duty_seq = '{0, 1, 2, 3, 2, 1, 0, 1};

    // Reset release: ROT_R of INIT_PATTERN
    start();
    check("rst_cfg_ready", cfg_ready, 1);
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) next_cycle();
      check("rst_tick", tick, (c % 4 == 3));
      exp_leds = (c < 5) ? 8'h3B : (c < 9) ? 8'h9D : 8'hCE;
      check("rst_leds", leds, exp_leds);
    end

    // STATIC 0xA5 offered at cycle 0
    start();
    offer(2'd0, 8'hA5);
    check("static_ready_c0", cfg_ready, 1);
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      cfg_valid = 1'b0;
      if (c <= 4) check("static_ready", cfg_ready, (c == 4));
      check("static_leds", leds, (c < 5) ? 8'h3B : 8'hA5);
    end

    // ROT_L 0x81
    start();
    offer(2'd2, 8'h81);
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      cfg_valid = 1'b0;
      if (c >= 5) begin
        exp_leds = (c < 9) ? 8'h81 : (c < 13) ? 8'h03 : 8'h06;
        check("rotl_leds", leds, exp_leds);
      end
    end

    // BREATHE 0xFF: duty changes each tick, leds gated by pwm_cnt (== cycle mod 4)
    start();
    offer(2'd3, 8'hFF);
    for (int c = 1; c <= 36; c++) begin
      next_cycle();
      cfg_valid = 1'b0;
      if (c == 4) begin
        check("breathe_pre", leds, 8'h3B);
      end else if (c >= 5) begin
        exp_leds = (((c - 1) % 4) < duty_seq[(c - 5) / 4]) ? 8'hFF : 8'h00;
        check("breathe_leds", leds, exp_leds);
      end
    end

    // Accept on the tick cycle, then back-pressure on a second request
    start();
    for (int c = 1; c <= 17; c++) begin
      next_cycle();
      if (c == 3) begin
        check("tkacc_tick", tick, 1);
        check("tkacc_ready3", cfg_ready, 1);
        offer(2'd0, 8'h5A);
      end else if (c >= 4 && c <= 8) begin
        offer(2'd2, 8'h11);
      end else begin
        cfg_valid = 1'b0;
      end
      if (c >= 4 && c <= 12) check("tkacc_ready", cfg_ready, (c == 8 || c == 12));
      if (c >= 5) begin
        exp_leds = (c < 9) ? 8'h9D : (c < 13) ? 8'h5A : (c < 17) ? 8'h11 : 8'h22;
        check("tkacc_leds", leds, exp_leds);
      end
    end

    // Reset while a config is pending and cfg_valid is still high
    start();
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 4) offer(2'd0, 8'h00);
    end
    check("rstpend_ready_c5", cfg_ready, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk_12mhz);
    reset = 1'b0;
    cfg_valid = 1'b0;
    cyc = 0;
    check("rstpend_ready", cfg_ready, 1);
    check("rstpend_leds", leds, 8'h3B);
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      check("rstpend_tick", tick, (c == 3 || c == 7));
      check("rstpend_ready_run", cfg_ready, 1);
      check("rstpend_run_leds", leds, (c < 5) ? 8'h3B : 8'h9D);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
